// File: rtl/if_mem_resp_pkg.sv
// if_mem_resp_pkg: shared widths, NOP encoding, response record and address-window check
package if_mem_resp_pkg;

   localparam int PC_WIDTH    = 64;
   localparam int INSTR_WIDTH = 32;
   localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [INSTR_WIDTH-1:0] instr;
      logic [PC_WIDTH-1:0]    pc;
      logic                   misalign;
      logic                   bus_err;
   } rsp_t;

   localparam int RSP_W = $bits(rsp_t);

   // limit is widened by one bit so a window ending at the top of the address space cannot wrap
   function automatic logic out_of_window(input logic [PC_WIDTH-1:0] pc,
                                          input logic [PC_WIDTH-1:0] base,
                                          input int unsigned        words);
      logic [PC_WIDTH:0] lim;
      lim = {1'b0, base} + {{(PC_WIDTH-33){1'b0}}, words, 2'b00};
      return (pc < base) || ({1'b0, pc} >= lim);
   endfunction

endpackage

// File: rtl/if_mem_resp_sync_fifo.sv
// if_mem_resp_sync_fifo: register-based response queue with flush and occupancy count
module if_mem_resp_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_flush,
   input  logic                         i_push,
   input  logic [WIDTH-1:0]             i_data,
   input  logic                         i_pop,
   output logic [WIDTH-1:0]             o_data,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wp;
   logic [PW-1:0]    r_rp;
   logic [CW-1:0]    r_cnt;
   logic             w_push;
   logic             w_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign w_push  = i_push & (r_cnt != CW'(DEPTH));
   assign w_pop   = i_pop & (r_cnt != '0);
   assign o_data  = r_mem[r_rp];
   assign o_empty = (r_cnt == '0);
   assign o_count = r_cnt;

   // pointer/count update; flush empties the queue exactly like reset
   always_ff @(posedge i_clk) begin
      if (i_rst | i_flush) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wp] <= i_data;
            r_wp        <= nxt(r_wp);
         end
         if (w_pop) r_rp <= nxt(r_rp);
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   end

endmodule

// File: rtl/if_mem_resp.sv
// if_mem_resp: instruction memory responder with fixed-latency pipe, in-order response queue and flush
module if_mem_resp
   import if_mem_resp_pkg::*;
#(
   parameter int                  MEM_WORDS = 4096,
   parameter logic [PC_WIDTH-1:0] BASE_ADDR = 64'h8000_0000,
   parameter int                  LATENCY   = 2,
   parameter int                  RSP_DEPTH = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          req_valid_i,
   output logic                          req_ready_o,
   input  logic [PC_WIDTH-1:0]           req_pc_i,
   input  logic                          flush_i,
   output logic                          rsp_valid_o,
   input  logic                          rsp_ready_i,
   output logic [INSTR_WIDTH-1:0]        rsp_instr_o,
   output logic [PC_WIDTH-1:0]           rsp_pc_o,
   output logic                          rsp_pc_misalign_o,
   output logic                          rsp_bus_err_o,
   input  logic                          init_we_i,
   input  logic [$clog2(MEM_WORDS)-1:0]  init_addr_i,
   input  logic [INSTR_WIDTH-1:0]        init_data_i
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam int CW = $clog2(RSP_DEPTH+1);
   localparam int OW = $clog2(RSP_DEPTH+LATENCY+1) + 1;

   logic [INSTR_WIDTH-1:0] r_mem [MEM_WORDS];
   logic [INSTR_WIDTH-1:0] r_rd;
   logic                   r_pv [LATENCY];
   rsp_t                   r_pd [LATENCY];
   rsp_t                   w_sd [LATENCY];
   rsp_t                   w_head;
   rsp_t                   w_fifo_q;
   logic [CW-1:0]          w_fifo_cnt;
   logic [OW-1:0]          w_out;
   logic [AW-1:0]          w_idx;
   logic                   w_mis;
   logic                   w_err;
   logic                   w_norm;
   logic                   w_acc;
   logic                   w_fifo_empty;
   logic                   w_rsp_v;
   logic                   w_pop;
   logic                   w_push;

   assign w_mis  = |req_pc_i[1:0];
   assign w_err  = !w_mis & out_of_window(req_pc_i, BASE_ADDR, MEM_WORDS);
   assign w_norm = !w_mis & !w_err;
   assign w_idx  = AW'((req_pc_i - BASE_ADDR) >> 2);
   assign w_acc  = req_valid_i & req_ready_o;

   // outstanding = occupied pipe stages + queued responses
   always_comb begin
      w_out = OW'(w_fifo_cnt);
      for (int k = 0; k < LATENCY; k++) w_out = w_out + OW'(r_pv[k]);
   end

   // a response leaving this cycle already frees its slot
   assign req_ready_o = !rst_i & !flush_i & (w_out < OW'(RSP_DEPTH) + OW'(w_pop));

   // preload / self-modify port
   always_ff @(posedge clk_i) begin
      if (init_we_i) r_mem[init_addr_i] <= init_data_i;
   end

   // registered array read, only for requests that decode as normal; a concurrent write yields old data
   always_ff @(posedge clk_i) begin
      if (w_acc & w_norm) r_rd <= r_mem[w_idx];
   end

   // stage valids: flush or reset drops everything in flight
   always_ff @(posedge clk_i) begin
      if (rst_i | flush_i) begin
         for (int k = 0; k < LATENCY; k++) r_pv[k] <= 1'b0;
      end else begin
         r_pv[0] <= w_acc;
         for (int k = 1; k < LATENCY; k++) r_pv[k] <= r_pv[k-1];
      end
   end

   // stage payloads: stage 0 captures pc/flags, later stages are plain delay registers
   always_ff @(posedge clk_i) begin
      if (w_acc) r_pd[0] <= '{instr: w_norm ? '0 : INSTR_NOP, pc: req_pc_i, misalign: w_mis, bus_err: w_err};
      for (int k = 1; k < LATENCY; k++) r_pd[k] <= w_sd[k-1];
   end

   // stage 0 merges the array read data for normal requests
   always_comb begin
      for (int k = 0; k < LATENCY; k++) w_sd[k] = r_pd[k];
      w_sd[0].instr = (r_pd[0].misalign | r_pd[0].bus_err) ? r_pd[0].instr : r_rd;
   end

   // last stage bypasses the queue when it is empty, otherwise it is queued behind older responses
   assign w_rsp_v = !w_fifo_empty | r_pv[LATENCY-1];
   assign w_pop   = w_rsp_v & rsp_ready_i;
   assign w_push  = r_pv[LATENCY-1] & !(w_fifo_empty & rsp_ready_i);
   assign w_head  = w_fifo_empty ? w_sd[LATENCY-1] : w_fifo_q;

   if_mem_resp_sync_fifo #(
      .WIDTH (RSP_W),
      .DEPTH (RSP_DEPTH)
   ) u_fifo (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_flush (flush_i),
      .i_push  (w_push),
      .i_data  (w_sd[LATENCY-1]),
      .i_pop   (rsp_ready_i & !w_fifo_empty),
      .o_data  (w_fifo_q),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_cnt)
   );

   assign rsp_valid_o       = w_rsp_v & !rst_i;
   assign rsp_instr_o       = rsp_valid_o ? w_head.instr : '0;
   assign rsp_pc_o          = rsp_valid_o ? w_head.pc : '0;
   assign rsp_pc_misalign_o = rsp_valid_o & w_head.misalign;
   assign rsp_bus_err_o     = rsp_valid_o & w_head.bus_err;

endmodule
